cpu_trace_buffer: RTL and testbench

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   Captures one commit record per retired instruction into a DEPTH-entry FIFO
//   and streams each record out as four 32-bit words over a valid/ready port:
//   pc, inst, {rf_we, 26'b0, waddr}, wdata (tr_last=1 on the final word).
//
// Parameters
//   DEPTH : number of records held in the FIFO (power of two, 4..64)
//   AW    : pointer width, must equal log2(DEPTH)
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-low reset
//   commit_*         retired-instruction record, captured when commit_valid=1
//   tr_valid/tr_ready/tr_data/tr_last   trace word stream
//   clr_overflow     clears overflow (a simultaneous drop wins)
//   overflow         sticky: at least one record was dropped
//   fifo_count       records stored, excluding the one being sent
//   drop_count       (only with `define TRACE_DROP_CNT_EN) saturating drop counter
module cpu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          commit_valid,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_inst,
    input  logic          commit_rf_we,
    input  logic [4:0]    commit_rf_waddr,
    input  logic [31:0]   commit_rf_wdata,
    output logic          tr_valid,
    input  logic          tr_ready,
    output logic [31:0]   tr_data,
    output logic          tr_last,
    input  logic          clr_overflow,
    output logic          overflow,
`ifdef TRACE_DROP_CNT_EN
    output logic [15:0]   drop_count,
`endif
    output logic [AW:0]   fifo_count
);

    typedef struct packed {
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } payload_t;

    typedef struct packed {
        logic [31:0] pc;
        payload_t    body;
    } rec_t;

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;

    state_t        state_q;
    payload_t      rec_q;      // words 1..3 of the record being sent
    logic [31:0]   tr_data_q;
    logic          tr_valid_q, tr_last_q;

    rec_t          head;
    rec_t          in_rec;
    logic          full, empty, xfer, pop, push, drop;

    always_comb begin
        head   = mem[rd_ptr_q];
        in_rec = '{pc: commit_pc,
                   body: '{inst: commit_inst, we: commit_rf_we,
                           waddr: commit_rf_waddr, wdata: commit_rf_wdata}};
        full   = (count_q == FULL_CNT);
        empty  = (count_q == '0);
        xfer   = tr_valid_q && tr_ready;
        // The head is popped straight into the output register, either from
        // IDLE or on the last word's transfer so records run back-to-back.
        pop    = !empty && ((state_q == IDLE) || (state_q == W3 && xfer));
        // A full FIFO still accepts a push when the same cycle frees a slot.
        push   = commit_valid && (!full || pop);
        drop   = commit_valid && full && !pop;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
    end

    // Storage is not reset; writes are still blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && push)
            mem[wr_ptr_q] <= in_rec;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (drop)
                overflow_q <= 1'b1;
            else if (clr_overflow)
                overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            tr_valid_q <= 1'b0;
            tr_data_q  <= '0;
            tr_last_q  <= 1'b0;
            rec_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q    <= W0;
                        tr_valid_q <= 1'b1;
                        tr_data_q  <= head.pc;
                        tr_last_q  <= 1'b0;
                        rec_q      <= head.body;
                    end
                end
                W0: begin
                    if (xfer) begin
                        state_q   <= W1;
                        tr_data_q <= rec_q.inst;
                    end
                end
                W1: begin
                    if (xfer) begin
                        state_q   <= W2;
                        tr_data_q <= {rec_q.we, 26'b0, rec_q.waddr};
                    end
                end
                W2: begin
                    if (xfer) begin
                        state_q   <= W3;
                        tr_data_q <= rec_q.wdata;
                        tr_last_q <= 1'b1;
                    end
                end
                W3: begin
                    if (xfer) begin
                        tr_last_q <= 1'b0;
                        if (pop) begin
                            state_q   <= W0;
                            tr_data_q <= head.pc;
                            rec_q     <= head.body;
                        end else begin
                            state_q    <= IDLE;
                            tr_valid_q <= 1'b0;
                            tr_data_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tr_valid_q <= 1'b0;
                    tr_data_q  <= '0;
                    tr_last_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_count_q;

    // A drop in the same cycle as a clear restarts the count at 1.
    always_ff @(posedge clk) begin
        if (!reset)
            drop_count_q <= '0;
        else if (drop && clr_overflow)
            drop_count_q <= 16'd1;
        else if (drop) begin
            if (drop_count_q != '1)
                drop_count_q <= drop_count_q + 16'd1;
        end else if (clr_overflow)
            drop_count_q <= '0;
    end

    assign drop_count = drop_count_q;
`endif

    assign tr_valid   = tr_valid_q;
    assign tr_data    = tr_data_q;
    assign tr_last    = tr_last_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Testbench for cpu_trace_buffer: directed vector table for single-record,
// backpressure and back-to-back streaming, plus hand-written sequences for
// overflow, full push+pop, ordered drain with pointer wrap, clr_overflow and
// mid-record reset. Build with +define+TRACE_DROP_CNT_EN to also check drop_count.
module tb_cpu_trace_buffer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          commit_valid;
    logic [31:0]   commit_pc, commit_inst, commit_rf_wdata;
    logic          commit_rf_we;
    logic [4:0]    commit_rf_waddr;
    logic          tr_valid, tr_ready, tr_last;
    logic [31:0]   tr_data;
    logic          clr_overflow, overflow;
    logic [AW:0]   fifo_count;
`ifdef TRACE_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_inst     (commit_inst),
        .commit_rf_we    (commit_rf_we),
        .commit_rf_waddr (commit_rf_waddr),
        .commit_rf_wdata (commit_rf_wdata),
        .tr_valid        (tr_valid),
        .tr_ready        (tr_ready),
        .tr_data         (tr_data),
        .tr_last         (tr_last),
        .clr_overflow    (clr_overflow),
        .overflow        (overflow),
`ifdef TRACE_DROP_CNT_EN
        .drop_count      (drop_count),
`endif
        .fifo_count      (fifo_count)
    );

    typedef struct {
        logic        cv;
        logic [31:0] pc, inst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [4:0]  ec;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic rdy, input logic ev, input logic [31:0] ed,
                                input logic el, input logic [4:0] ec);
        vec_t v;
        v.cv = cv; v.pc = pc; v.inst = inst; v.we = we; v.wa = wa; v.wd = wd;
        v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el; v.ec = ec;
        return v;
    endfunction

    function automatic vec_t nc(input logic rdy, input logic ev, input logic [31:0] ed,
                                input logic el, input logic [4:0] ec);
        return mk(1'b0, '0, '0, 1'b0, '0, '0, rdy, ev, ed, el, ec);
    endfunction

    // Numbered records used by the fill / drain sequences.
    function automatic logic [31:0] rec_word(input logic [31:0] i, input int w);
        case (w)
            0:       return 32'h0000_1000 + i;
            1:       return 32'h0000_2000 + i;
            2:       return {i[0], 26'b0, i[4:0]};
            default: return 32'h0000_3000 + i;
        endcase
    endfunction

    task automatic drive_rec(input logic [31:0] i);
        commit_valid    = 1'b1;
        commit_pc       = rec_word(i, 0);
        commit_inst     = rec_word(i, 1);
        commit_rf_we    = i[0];
        commit_rf_waddr = i[4:0];
        commit_rf_wdata = rec_word(i, 3);
    endtask

    task automatic fill(input int n);
        tr_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_rec(i);
            tick();
        end
        commit_valid = 1'b0;
    endtask

    vec_t vt[$];
    int   order[$];

    initial begin
        reset = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_inst = '0;
        commit_rf_we = 1'b0; commit_rf_waddr = '0; commit_rf_wdata = '0;
        tr_ready = 1'b0; clr_overflow = 1'b0;

        // Single commit, full throughput
        vt.push_back(mk(1, 32'h0040_0000, 32'h3c01_0000, 1, 5'd1, 32'h0, 1, 0, 0, 0, 5'd1));
        vt.push_back(nc(1, 1, 32'h0040_0000, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h3c01_0000, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h8000_0001, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h0000_0000, 1, 5'd0));
        vt.push_back(nc(1, 0, 32'h0, 0, 5'd0));
        // Backpressure: 5 stalled cycles on word 1
        vt.push_back(mk(1, 32'h0000_1000, 32'h1234_5678, 0, 5'd31, 32'hdead_beef, 0, 0, 0, 0, 5'd1));
        vt.push_back(nc(0, 1, 32'h0000_1000, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h1234_5678, 0, 5'd0));
        for (int i = 0; i < 5; i++) vt.push_back(nc(0, 1, 32'h1234_5678, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h0000_001f, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'hdead_beef, 1, 5'd0));
        vt.push_back(nc(1, 0, 32'h0, 0, 5'd0));
        // Two consecutive commits stream with no bubble between records
        vt.push_back(mk(1, 32'h0000_0100, 32'h0000_0111, 1, 5'd2, 32'h0000_0222, 1, 0, 0, 0, 5'd1));
        vt.push_back(mk(1, 32'h0000_0200, 32'h0000_0333, 0, 5'd0, 32'h0000_0444, 1, 1, 32'h0000_0100, 0, 5'd1));
        vt.push_back(nc(1, 1, 32'h0000_0111, 0, 5'd1));
        vt.push_back(nc(1, 1, 32'h8000_0002, 0, 5'd1));
        vt.push_back(nc(1, 1, 32'h0000_0222, 1, 5'd1));
        vt.push_back(nc(1, 1, 32'h0000_0200, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h0000_0333, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h0000_0000, 0, 5'd0));
        vt.push_back(nc(1, 1, 32'h0000_0444, 1, 5'd0));
        vt.push_back(nc(1, 0, 32'h0, 0, 5'd0));

        // Reset state
        tick(); tick();
        chk("rst.valid", tr_valid, 0);
        chk("rst.data", tr_data, 0);
        chk("rst.last", tr_last, 0);
        chk("rst.count", fifo_count, 0);
        chk("rst.ovf", overflow, 0);
`ifdef TRACE_DROP_CNT_EN
        chk("rst.dropcnt", drop_count, 0);
`endif
        reset = 1'b1;
        tick();

        foreach (vt[k]) begin
            commit_valid = vt[k].cv; commit_pc = vt[k].pc; commit_inst = vt[k].inst;
            commit_rf_we = vt[k].we; commit_rf_waddr = vt[k].wa; commit_rf_wdata = vt[k].wd;
            tr_ready = vt[k].rdy;
            tick();
            chk($sformatf("vec%0d.valid", k), tr_valid, vt[k].ev);
            chk($sformatf("vec%0d.count", k), fifo_count, vt[k].ec);
            chk($sformatf("vec%0d.ovf", k), overflow, 0);
            if (vt[k].ev) begin
                chk($sformatf("vec%0d.data", k), tr_data, vt[k].ed);
                chk($sformatf("vec%0d.last", k), tr_last, vt[k].el);
            end
        end

        // Fill: 17 commits fill FIFO (one record in output register), 18th drops
        fill(17);
        chk("fill17.count", fifo_count, 16);
        chk("fill17.ovf", overflow, 0);
        drive_rec(17);
        tick();
        commit_valid = 1'b0;
        chk("fill18.count", fifo_count, 16);
        chk("fill18.ovf", overflow, 1);
        chk("fill18.data", tr_data, rec_word(0, 0));
`ifdef TRACE_DROP_CNT_EN
        chk("fill18.dropcnt", drop_count, 1);
`endif

        // Move record 0 to its last word while full
        tr_ready = 1'b1;
        for (int w = 1; w < 4; w++) begin
            tick();
            chk($sformatf("full.w%0d.data", w), tr_data, rec_word(0, w));
            chk($sformatf("full.w%0d.count", w), fifo_count, 16);
        end
        chk("full.w3.last", tr_last, 1);
        // Push and pop together on the W3 transfer while full
        drive_rec(18);
        tick();
        commit_valid = 1'b0;
        tr_ready = 1'b0;
        chk("pushpop.count", fifo_count, 16);
        chk("pushpop.ovf", overflow, 1);
        chk("pushpop.data", tr_data, rec_word(1, 0));
        chk("pushpop.last", tr_last, 0);

        // clr_overflow together with a drop: drop wins
        clr_overflow = 1'b1;
        drive_rec(19);
        tick();
        commit_valid = 1'b0;
        chk("clrdrop.ovf", overflow, 1);
        chk("clrdrop.count", fifo_count, 16);
`ifdef TRACE_DROP_CNT_EN
        chk("clrdrop.dropcnt", drop_count, 1);
`endif
        // clr_overflow alone
        tick();
        clr_overflow = 1'b0;
        chk("clr.ovf", overflow, 0);
`ifdef TRACE_DROP_CNT_EN
        chk("clr.dropcnt", drop_count, 0);
`endif

        // Drain: records 1..16 then 18, in order, across pointer wrap
        for (int r = 1; r <= 16; r++) order.push_back(r);
        order.push_back(18);
        tr_ready = 1'b1;
        foreach (order[k]) begin
            for (int w = 0; w < 4; w++) begin
                chk($sformatf("drain.r%0d.w%0d.valid", order[k], w), tr_valid, 1);
                chk($sformatf("drain.r%0d.w%0d.data", order[k], w), tr_data, rec_word(order[k], w));
                chk($sformatf("drain.r%0d.w%0d.last", order[k], w), tr_last, (w == 3));
                tick();
            end
        end
        chk("drain.valid", tr_valid, 0);
        chk("drain.count", fifo_count, 0);

        // Reset mid-record (during word 2), with overflow set and FIFO full
        fill(18);
        chk("refill.ovf", overflow, 1);
        tr_ready = 1'b1;
        tick(); tick();
        chk("midrst.pre.data", tr_data, rec_word(0, 2));
        reset = 1'b0;
        drive_rec(40);
        tick();
        commit_valid = 1'b0;
        chk("midrst.valid", tr_valid, 0);
        chk("midrst.count", fifo_count, 0);
        chk("midrst.ovf", overflow, 0);
        chk("midrst.last", tr_last, 0);
`ifdef TRACE_DROP_CNT_EN
        chk("midrst.dropcnt", drop_count, 0);
`endif
        reset = 1'b1;
        tick();
        chk("postrst.valid", tr_valid, 0);
        chk("postrst.count", fifo_count, 0);
        commit_valid = 1'b1; commit_pc = 32'hABCD_0000; commit_inst = 32'h0000_5555;
        commit_rf_we = 1'b1; commit_rf_waddr = 5'd7; commit_rf_wdata = 32'h0000_7777;
        tick();
        commit_valid = 1'b0;
        chk("newrec.count", fifo_count, 1);
        chk("newrec.valid0", tr_valid, 0);
        tick();
        chk("newrec.valid", tr_valid, 1);
        chk("newrec.w0", tr_data, 32'hABCD_0000);
        tick();
        chk("newrec.w1", tr_data, 32'h0000_5555);
        tick();
        chk("newrec.w2", tr_data, 32'h8000_0007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
